// File: rtl/gba_sound_mixer.sv
// Stereo DMA/PSG mixer: per-side sum, SOUNDBIAS offset, 10-bit DAC clamp and 16-bit PCM output.
// Optional macro SOUND_MIX_FILTER_EN averages each DAC code with the previous unfiltered code.
module gba_sound_mixer #(
  parameter int unsigned SAMPLE_DIV = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        master_enable,
  input  logic [15:0] psg_left,
  input  logic [15:0] psg_right,
  input  logic [1:0]  psg_volume,
  input  logic [15:0] dma_a_left,
  input  logic [15:0] dma_a_right,
  input  logic [15:0] dma_b_left,
  input  logic [15:0] dma_b_right,
  input  logic [9:0]  bias_level,
  output logic [9:0]  out_dac_left,
  output logic [9:0]  out_dac_right,
  output logic [15:0] out_pcm_left,
  output logic [15:0] out_pcm_right,
  output logic        out_valid,
  output logic        busy
);

  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_ADD_PSG = 3'd2,
    S_ADD_A   = 3'd3,
    S_ADD_B   = 3'd4,
    S_CLAMP   = 3'd5
  } state_t;

  function automatic logic [18:0] sext16(input logic [15:0] v);
    return {{3{v[15]}}, v};
  endfunction

  // Arithmetic shift: volume codes 0 and 3 both mean 25%.
  function automatic logic [18:0] psg_scale(input logic [15:0] p, input logic [1:0] vol);
    logic [18:0] x;
    x = sext16(p);
    case (vol)
      2'd1:    return {x[18], x[18:1]};
      2'd2:    return x;
      default: return {x[18], x[18], x[18:2]};
    endcase
  endfunction

  function automatic logic [9:0] clamp_dac(input logic [18:0] acc, input logic [9:0] bias);
    logic [19:0] s;
    s = {acc[18], acc} + {10'd0, bias};
    if (s[19]) begin
      return 10'd0;
    end else if (|s[18:10]) begin
      return 10'h3FF;
    end else begin
      return s[9:0];
    end
  endfunction

  // (dac - 512) << 6 is just the offset-binary code with its top bit flipped.
  function automatic logic [15:0] dac_to_pcm(input logic [9:0] d);
    return {~d[9], d[8:0], 6'd0};
  endfunction

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [18:0]      acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic             me_q;
  logic [1:0]       vol_q;
  logic [15:0]      psg_l_q, psg_r_q, a_l_q, a_r_q, b_l_q, b_r_q;
  logic [9:0]       bias_q;
  logic [9:0]       dac_l_q, dac_l_d, dac_r_q, dac_r_d;
  logic [15:0]      pcm_l_q, pcm_l_d, pcm_r_q, pcm_r_d;
  logic             valid_q, valid_d;
  logic             tick_s;
  logic [9:0]       raw_l_s, raw_r_s, filt_l_s, filt_r_s;

`ifdef SOUND_MIX_FILTER_EN
  logic [9:0]  prev_l_q, prev_l_d, prev_r_q, prev_r_d;
  logic [10:0] sum_l_s, sum_r_s;
`endif

  assign tick_s = (div_q == DIV_W'(SAMPLE_DIV - 1));

  always_comb begin
    div_d    = tick_s ? '0 : div_q + {{(DIV_W-1){1'b0}}, 1'b1};
    state_d  = state_q;
    acc_l_d  = acc_l_q;
    acc_r_d  = acc_r_q;
    dac_l_d  = dac_l_q;
    dac_r_d  = dac_r_q;
    pcm_l_d  = pcm_l_q;
    pcm_r_d  = pcm_r_q;
    valid_d  = 1'b0;
    raw_l_s  = clamp_dac(acc_l_q, bias_q);
    raw_r_s  = clamp_dac(acc_r_q, bias_q);
`ifdef SOUND_MIX_FILTER_EN
    prev_l_d = prev_l_q;
    prev_r_d = prev_r_q;
    sum_l_s  = {1'b0, raw_l_s} + {1'b0, prev_l_q};
    sum_r_s  = {1'b0, raw_r_s} + {1'b0, prev_r_q};
    filt_l_s = sum_l_s[10:1];
    filt_r_s = sum_r_s[10:1];
`else
    filt_l_s = raw_l_s;
    filt_r_s = raw_r_s;
`endif
    case (state_q)
      S_IDLE: begin
        if (tick_s) begin
          state_d = S_CAPTURE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CAPTURE: state_d = S_ADD_PSG;
      S_ADD_PSG: begin
        acc_l_d = me_q ? psg_scale(psg_l_q, vol_q) : 19'd0;
        acc_r_d = me_q ? psg_scale(psg_r_q, vol_q) : 19'd0;
        state_d = S_ADD_A;
      end
      S_ADD_A: begin
        acc_l_d = me_q ? acc_l_q + sext16(a_l_q) : 19'd0;
        acc_r_d = me_q ? acc_r_q + sext16(a_r_q) : 19'd0;
        state_d = S_ADD_B;
      end
      S_ADD_B: begin
        acc_l_d = me_q ? acc_l_q + sext16(b_l_q) : 19'd0;
        acc_r_d = me_q ? acc_r_q + sext16(b_r_q) : 19'd0;
        state_d = S_CLAMP;
      end
      S_CLAMP: begin
        dac_l_d = filt_l_s;
        dac_r_d = filt_r_s;
        pcm_l_d = dac_to_pcm(filt_l_s);
        pcm_r_d = dac_to_pcm(filt_r_s);
        valid_d = 1'b1;
`ifdef SOUND_MIX_FILTER_EN
        prev_l_d = raw_l_s;
        prev_r_d = raw_r_s;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      acc_l_q <= 19'd0;
      acc_r_q <= 19'd0;
      dac_l_q <= 10'h200;
      dac_r_q <= 10'h200;
      pcm_l_q <= 16'd0;
      pcm_r_q <= 16'd0;
      valid_q <= 1'b0;
`ifdef SOUND_MIX_FILTER_EN
      prev_l_q <= 10'h200;
      prev_r_q <= 10'h200;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      dac_l_q <= dac_l_d;
      dac_r_q <= dac_r_d;
      pcm_l_q <= pcm_l_d;
      pcm_r_q <= pcm_r_d;
      valid_q <= valid_d;
`ifdef SOUND_MIX_FILTER_EN
      prev_l_q <= prev_l_d;
      prev_r_q <= prev_r_d;
`endif
    end
  end

  // Input snapshot: the rest of the mix sees only these copies.
  always_ff @(posedge clk) begin
    if (!reset) begin
      me_q    <= 1'b0;
      vol_q   <= 2'd0;
      psg_l_q <= 16'd0;
      psg_r_q <= 16'd0;
      a_l_q   <= 16'd0;
      a_r_q   <= 16'd0;
      b_l_q   <= 16'd0;
      b_r_q   <= 16'd0;
      bias_q  <= 10'd0;
    end else if (state_q == S_CAPTURE) begin
      me_q    <= master_enable;
      vol_q   <= psg_volume;
      psg_l_q <= psg_left;
      psg_r_q <= psg_right;
      a_l_q   <= dma_a_left;
      a_r_q   <= dma_a_right;
      b_l_q   <= dma_b_left;
      b_r_q   <= dma_b_right;
      bias_q  <= bias_level;
    end
  end

  assign out_dac_left  = dac_l_q;
  assign out_dac_right = dac_r_q;
  assign out_pcm_left  = pcm_l_q;
  assign out_pcm_right = pcm_r_q;
  assign out_valid     = valid_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_gba_sound_mixer.sv
// Directed bench for gba_sound_mixer: reset, timing, mixing, clamping, master enable and abort.
module tb_gba_sound_mixer;

  localparam int DIV = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic        master_enable;
  logic [15:0] psg_left, psg_right, dma_a_left, dma_a_right, dma_b_left, dma_b_right;
  logic [1:0]  psg_volume;
  logic [9:0]  bias_level;
  logic [9:0]  out_dac_left, out_dac_right;
  logic [15:0] out_pcm_left, out_pcm_right;
  logic        out_valid, busy;

  int passed = 0;
  int total  = 0;
  int failed = 0;
  int n;
  int seen;
  logic [9:0] prev_l, prev_r;

  gba_sound_mixer #(.SAMPLE_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .master_enable(master_enable),
    .psg_left(psg_left), .psg_right(psg_right), .psg_volume(psg_volume),
    .dma_a_left(dma_a_left), .dma_a_right(dma_a_right),
    .dma_b_left(dma_b_left), .dma_b_right(dma_b_right),
    .bias_level(bias_level),
    .out_dac_left(out_dac_left), .out_dac_right(out_dac_right),
    .out_pcm_left(out_pcm_left), .out_pcm_right(out_pcm_right),
    .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edges from now until out_valid is seen; a timeout counts as a failed check.
  task automatic wait_valid(input string tag, output int cnt);
    cnt = 0;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (out_valid) return;
    end
    check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  function automatic logic [15:0] pcm_of(input logic [9:0] d);
    int v;
    v = (int'(d) - 512) * 64;
    return v[15:0];
  endfunction

  // Hand-computed raw DAC codes; the filtered build averages with the previous raw code.
  task automatic expect_sample(input string tag, input logic [9:0] raw_l, input logic [9:0] raw_r);
    logic [9:0] el, er;
`ifdef SOUND_MIX_FILTER_EN
    el = 10'((11'(raw_l) + 11'(prev_l)) >> 1);
    er = 10'((11'(raw_r) + 11'(prev_r)) >> 1);
`else
    el = raw_l;
    er = raw_r;
`endif
    prev_l = raw_l;
    prev_r = raw_r;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_dac_l"}, 32'(out_dac_left), 32'(el));
    check({tag, "_dac_r"}, 32'(out_dac_right), 32'(er));
    check({tag, "_pcm_l"}, 32'(out_pcm_left), 32'(pcm_of(el)));
    check({tag, "_pcm_r"}, 32'(out_pcm_right), 32'(pcm_of(er)));
  endtask

  task automatic set_inputs(input logic me, input logic [1:0] vol,
                            input logic [15:0] pl, input logic [15:0] pr,
                            input logic [15:0] al, input logic [15:0] ar,
                            input logic [15:0] bl, input logic [15:0] br,
                            input logic [9:0] bias);
    master_enable = me;  psg_volume = vol;
    psg_left = pl;       psg_right = pr;
    dma_a_left = al;     dma_a_right = ar;
    dma_b_left = bl;     dma_b_right = br;
    bias_level = bias;
  endtask

  initial begin
    prev_l = 10'h200;
    prev_r = 10'h200;
    reset = 1'b0;
    set_inputs(1'b1, 2'd2, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 10'h200);
    repeat (10) @(posedge clk);
    #1;
    check("rst_dac_l", 32'(out_dac_left), 32'h200);
    check("rst_dac_r", 32'(out_dac_right), 32'h200);
    check("rst_pcm_l", 32'(out_pcm_left), 32'h0);
    check("rst_pcm_r", 32'(out_pcm_right), 32'h0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;

    wait_valid("first", n);
    check("first_latency", 32'(n), 32'(DIV + 5));
    expect_sample("zero0", 10'h200, 10'h200);
    @(posedge clk);
    #1;
    check("valid_pulse_width", 32'(out_valid), 32'd0);
    wait_valid("period", n);
    check("valid_period", 32'(n), 32'(DIV - 1));
    expect_sample("zero1", 10'h200, 10'h200);

    set_inputs(1'b1, 2'd0, 16'h0100, 16'h0100, 16'd0, 16'd0, 16'd0, 16'd0, 10'h200);
    wait_valid("vol0", n);
    expect_sample("vol0", 10'h240, 10'h240);
    psg_volume = 2'd2;
    wait_valid("vol2", n);
    expect_sample("vol2", 10'h300, 10'h300);
    psg_volume = 2'd3;
    wait_valid("vol3", n);
    expect_sample("vol3", 10'h240, 10'h240);
    // -257 >>> 1 = -129 -> 512-129 = 0x17F; right 256>>>1 = 128 -> 0x280
    set_inputs(1'b1, 2'd1, 16'hFEFF, 16'h0100, 16'd0, 16'd0, 16'd0, 16'd0, 10'h200);
    wait_valid("vol1", n);
    expect_sample("vol1", 10'h17F, 10'h280);

    set_inputs(1'b1, 2'd2, 16'd0, 16'd0, 16'd508, 16'd508, 16'd508, 16'd508, 10'h200);
    wait_valid("clamp_hi", n);
    expect_sample("clamp_hi", 10'h3FF, 10'h3FF);
    set_inputs(1'b1, 2'd2, 16'd0, 16'd0, 16'd511, 16'd0, 16'd0, 16'hFE00, 10'h200);
    wait_valid("edges", n);
    expect_sample("edges", 10'h3FF, 10'h000);
    set_inputs(1'b1, 2'd2, 16'd0, 16'd0, 16'hFE00, 16'hFE00, 16'hFE00, 16'hFE00, 10'h200);
    wait_valid("clamp_lo", n);
    expect_sample("clamp_lo", 10'h000, 10'h000);

    set_inputs(1'b0, 2'd2, 16'h1234, 16'hF000, 16'd300, 16'hFF00, 16'd77, 16'd99, 10'h180);
    wait_valid("me_off", n);
    expect_sample("me_off", 10'h180, 10'h180);

    set_inputs(1'b1, 2'd2, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 10'h200);
    wait_valid("pre_abort", n);
    expect_sample("pre_abort", 10'h200, 10'h200);
    set_inputs(1'b1, 2'd2, 16'd0, 16'd0, 16'd511, 16'd511, 16'd0, 16'd0, 10'h200);
    // Tick lands 506 edges after a valid; 509 edges later the mix sits in ADD_A.
    seen = 0;
    for (int i = 0; i < 509; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("abort_no_early_valid", 32'(seen), 32'd0);
    check("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_dac_l", 32'(out_dac_left), 32'h200);
    check("abort_pcm_r", 32'(out_pcm_right), 32'h0);
    prev_l = 10'h200;
    prev_r = 10'h200;
    wait_valid("post_abort", n);
    check("post_abort_latency", 32'(n), 32'(DIV + 5));
    expect_sample("step1", 10'h3FF, 10'h3FF);
    wait_valid("step2", n);
    expect_sample("step2", 10'h3FF, 10'h3FF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
